// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline sequencer and its environment.
// Breakpoint signals exist only when PIPE_SEQ_BREAKPOINT_EN is defined.
interface pipeline_sequencer_if #(
    parameter int RNBITS  = 5,
    parameter int CNTBITS = 32
);
    logic               i_start;
    logic               i_mode_step;
    logic               i_step;
    logic               i_halt_detected;
    logic [RNBITS-1:0]  i_ID_rs;
    logic [RNBITS-1:0]  i_ID_rt;
    logic [RNBITS-1:0]  i_EX_RegistroDestino;
    logic               i_EX_MemRead;
    logic               i_branch_taken;
`ifdef PIPE_SEQ_BREAKPOINT_EN
    logic               i_bp_valid;
    logic [31:0]        i_bp_addr;
    logic [31:0]        i_pc;
`endif
    logic               o_pc_en;
    logic               o_IF_ID_en;
    logic               o_ID_EX_en;
    logic               o_EX_MEM_en;
    logic               o_MEM_WB_en;
    logic               o_IF_ID_flush;
    logic               o_ID_EX_bubble;
    logic               o_running;
    logic               o_halted;
    logic               o_step_done;
    logic [CNTBITS-1:0] o_cycle_count;

    modport master (
        output i_start, i_mode_step, i_step, i_halt_detected,
               i_ID_rs, i_ID_rt, i_EX_RegistroDestino, i_EX_MemRead, i_branch_taken,
`ifdef PIPE_SEQ_BREAKPOINT_EN
               i_bp_valid, i_bp_addr, i_pc,
`endif
        input  o_pc_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en,
               o_IF_ID_flush, o_ID_EX_bubble, o_running, o_halted, o_step_done,
               o_cycle_count
    );

    modport slave (
        input  i_start, i_mode_step, i_step, i_halt_detected,
               i_ID_rs, i_ID_rt, i_EX_RegistroDestino, i_EX_MemRead, i_branch_taken,
`ifdef PIPE_SEQ_BREAKPOINT_EN
               i_bp_valid, i_bp_addr, i_pc,
`endif
        output o_pc_en, o_IF_ID_en, o_ID_EX_en, o_EX_MEM_en, o_MEM_WB_en,
               o_IF_ID_flush, o_ID_EX_bubble, o_running, o_halted, o_step_done,
               o_cycle_count
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Five-stage MIPS pipeline controller: run/step/halt sequencing plus load-use and branch hazards.
// Optional PC breakpoint support is compiled in with PIPE_SEQ_BREAKPOINT_EN.
module pipeline_sequencer #(
    parameter int RNBITS       = 5,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNTBITS      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    pipeline_sequencer_if.slave   bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RUN       = 3'd1;
    localparam logic [2:0] STEP_WAIT = 3'd2;
    localparam logic [2:0] STEP_EXEC = 3'd3;
    localparam logic [2:0] DRAIN     = 3'd4;
    localparam logic [2:0] HALTED    = 3'd5;

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [DW-1:0]      drain_cnt;
    logic               step_prev;
    logic               step_rise;
    logic               step_done;
    logic [CNTBITS-1:0] cycle_count;
    logic [RNBITS-1:0]  ex_dest;
    logic               stall;
    logic               bp_hit;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;

    assign ex_dest   = bus.i_EX_RegistroDestino;
    assign step_rise = bus.i_step & ~step_prev;
    assign stall     = bus.i_EX_MemRead && (ex_dest != '0) &&
                       ((ex_dest == bus.i_ID_rs) || (ex_dest == bus.i_ID_rt));

`ifdef PIPE_SEQ_BREAKPOINT_EN
    logic        bp_fired;
    logic [31:0] pc_prev;

    assign bp_hit = (state == RUN) && bus.i_bp_valid &&
                    (bus.i_pc == bus.i_bp_addr) && !bp_fired;

    // One-shot: once a breakpoint fires it stays masked until the PC moves on.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bp_fired <= 1'b0;
            pc_prev  <= '0;
        end else begin
            pc_prev <= bus.i_pc;
            if (bp_hit)
                bp_fired <= 1'b1;
            else if (bus.i_pc != pc_prev)
                bp_fired <= 1'b0;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    always_comb begin
        next_state   = state;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start)
                    next_state = bus.i_mode_step ? STEP_WAIT : RUN;
            end
            RUN, STEP_EXEC: begin
                if (bp_hit) begin
                    next_state = STEP_WAIT;
                end else begin
                    pc_en       = ~stall;
                    if_id_en    = ~stall;
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    id_ex_bubble = stall;
                    if_id_flush = bus.i_branch_taken & ~stall;
                    // A stalled HALT is not yet committed; it is taken once the stall clears.
                    if (bus.i_halt_detected && !stall)
                        next_state = DRAIN;
                    else if (state == STEP_EXEC || bus.i_mode_step)
                        next_state = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (!bus.i_mode_step)
                    next_state = RUN;
                else if (step_rise)
                    next_state = STEP_EXEC;
            end
            DRAIN: begin
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                id_ex_bubble = 1'b1;
                if (drain_cnt == DW'(1))
                    next_state = HALTED;
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            step_prev   <= 1'b0;
            step_done   <= 1'b0;
            cycle_count <= '0;
        end else begin
            state     <= next_state;
            step_prev <= bus.i_step;
            step_done <= (state == STEP_EXEC);
            if (state != DRAIN && next_state == DRAIN)
                drain_cnt <= DW'(DRAIN_CYCLES);
            else if (state == DRAIN)
                drain_cnt <= drain_cnt - DW'(1);
            if (mem_wb_en && cycle_count != '1)
                cycle_count <= cycle_count + CNTBITS'(1);
        end
    end

    assign bus.o_pc_en        = pc_en;
    assign bus.o_IF_ID_en     = if_id_en;
    assign bus.o_ID_EX_en     = id_ex_en;
    assign bus.o_EX_MEM_en    = ex_mem_en;
    assign bus.o_MEM_WB_en    = mem_wb_en;
    assign bus.o_IF_ID_flush  = if_id_flush;
    assign bus.o_ID_EX_bubble = id_ex_bubble;
    assign bus.o_running      = (state == RUN) || (state == STEP_EXEC);
    assign bus.o_halted       = (state == HALTED);
    assign bus.o_step_done    = step_done;
    assign bus.o_cycle_count  = cycle_count;
endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: stimulus queues expected outputs, a monitor checks them.
// Exercises reset, run, hazards, single-step and halt-drain in the default build.
module tb_pipeline_sequencer;
    localparam logic [9:0] IDLE_F  = 10'b00000_00_000;
    localparam logic [9:0] RUN_F   = 10'b11111_00_100;
    localparam logic [9:0] STALL_F = 10'b00111_01_100;
    localparam logic [9:0] FLUSH_F = 10'b11111_10_100;
    localparam logic [9:0] DRAIN_F = 10'b00111_01_000;
    localparam logic [9:0] HALT_F  = 10'b00000_00_010;
    localparam logic [9:0] WAIT_F  = 10'b00000_00_000;
    localparam logic [9:0] DONE_F  = 10'b00000_00_001;

    typedef struct {
        string       name;
        logic [9:0]  flags;
        logic [31:0] count;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    exp_t expq[$];

    pipeline_sequencer_if #(.RNBITS(5), .CNTBITS(32)) bus ();

    pipeline_sequencer #(.RNBITS(5), .DRAIN_CYCLES(4), .CNTBITS(32)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not complete, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input exp_t e);
        logic [9:0] act;
        act = {bus.o_pc_en, bus.o_IF_ID_en, bus.o_ID_EX_en, bus.o_EX_MEM_en, bus.o_MEM_WB_en,
               bus.o_IF_ID_flush, bus.o_ID_EX_bubble, bus.o_running, bus.o_halted, bus.o_step_done};
        checks++;
        if (act !== e.flags) begin
            errors++;
            $display("[TB] FAIL %s flags: actual=%b required=%b (pc,ifid,idex,exmem,memwb,flush,bubble,run,halt,done)",
                     e.name, act, e.flags);
        end
        checks++;
        if (bus.o_cycle_count !== e.count) begin
            errors++;
            $display("[TB] FAIL %s cycle_count: actual=%0d required=%0d", e.name, bus.o_cycle_count, e.count);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) checkOutput(expq.pop_front());
        end
    end

    task automatic driveInputs(input logic start, input logic ms, input logic step, input logic halt,
                               input logic memread, input logic [4:0] exd, input logic [4:0] rs,
                               input logic [4:0] rt, input logic branch);
        bus.i_start              = start;
        bus.i_mode_step          = ms;
        bus.i_step               = step;
        bus.i_halt_detected      = halt;
        bus.i_EX_MemRead         = memread;
        bus.i_EX_RegistroDestino = exd;
        bus.i_ID_rs              = rs;
        bus.i_ID_rt              = rt;
        bus.i_branch_taken       = branch;
    endtask

    task automatic applyStimulus(input string name, input logic start, input logic ms, input logic step,
                                 input logic halt, input logic memread, input logic [4:0] exd,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic branch,
                                 input logic [9:0] flags, input logic [31:0] count);
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(start, ms, step, halt, memread, exd, rs, rt, branch);
        e.name  = name;
        e.flags = flags;
        e.count = count;
        expq.push_back(e);
    endtask

    task automatic applyAsyncReset();
        exp_t e;
        @(posedge clk);
        #1;
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        e.name  = "reset_async";
        e.flags = IDLE_F;
        e.count = 32'd0;
        expq.push_back(e);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
`ifdef PIPE_SEQ_BREAKPOINT_EN
        bus.i_bp_valid = 1'b0;
        bus.i_bp_addr  = 32'h0;
        bus.i_pc       = 32'h0;
`endif
        driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("[TB] reset and run");
        applyStimulus("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_F, 0);
        reset_n = 1'b1;
        applyStimulus("idle_start", 1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_F, 0);
        applyStimulus("run_enter",  0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_F, 0);
        for (int i = 1; i <= 6; i++)
            applyStimulus("run_count", 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_F, 32'(i));
        applyAsyncReset();
        applyStimulus("restart_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_F, 0);
        applyStimulus("restart_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_F, 0);

        $display("[TB] hazards");
        applyStimulus("stall_rt",        0, 0, 0, 0, 1, 5, 0, 5, 0, STALL_F, 1);
        applyStimulus("no_stall_dest0",  0, 0, 0, 0, 1, 0, 0, 0, 0, RUN_F,   2);
        applyStimulus("no_stall_noload", 0, 0, 0, 0, 0, 5, 0, 5, 0, RUN_F,   3);
        applyStimulus("stall_rs",        0, 0, 0, 0, 1, 7, 7, 1, 0, STALL_F, 4);
        applyStimulus("branch_flush",    0, 0, 0, 0, 0, 0, 0, 0, 1, FLUSH_F, 5);
        applyStimulus("branch_vs_stall", 0, 0, 0, 0, 1, 3, 3, 0, 1, STALL_F, 6);
        applyStimulus("halt_deferred",   0, 0, 0, 1, 1, 3, 0, 3, 0, STALL_F, 7);
        applyStimulus("run_after_defer", 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_F,   8);

        $display("[TB] single step");
        applyStimulus("run_mode_step", 0, 1, 0, 0, 0, 0, 0, 0, 0, RUN_F,  9);
        applyStimulus("step_wait",     0, 1, 1, 0, 0, 0, 0, 0, 0, WAIT_F, 10);
        applyStimulus("step_exec",     0, 1, 1, 0, 0, 0, 0, 0, 0, RUN_F,  10);
        applyStimulus("step_done",     0, 1, 1, 0, 0, 0, 0, 0, 0, DONE_F, 11);
        for (int i = 0; i < 7; i++)
            applyStimulus("step_held", 0, 1, 1, 0, 0, 0, 0, 0, 0, WAIT_F, 11);
        applyStimulus("step_low",      0, 1, 0, 0, 0, 0, 0, 0, 0, WAIT_F, 11);
        applyStimulus("step2_edge",    0, 1, 1, 0, 0, 0, 0, 0, 0, WAIT_F, 11);
        applyStimulus("step2_exec",    0, 1, 0, 0, 0, 0, 0, 0, 0, RUN_F,  11);
        applyStimulus("step2_done",    0, 1, 0, 0, 0, 0, 0, 0, 0, DONE_F, 12);
        applyStimulus("leave_step",    0, 0, 0, 0, 0, 0, 0, 0, 0, WAIT_F, 12);
        applyStimulus("back_to_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, RUN_F,  12);

        $display("[TB] halt drain");
        applyStimulus("halt_decode",   0, 0, 0, 1, 0, 0, 0, 0, 0, RUN_F,   13);
        applyStimulus("drain_1",       0, 0, 0, 0, 1, 2, 2, 0, 0, DRAIN_F, 14);
        applyStimulus("drain_2",       0, 0, 0, 0, 0, 0, 0, 0, 1, DRAIN_F, 15);
        applyStimulus("drain_3",       0, 1, 0, 0, 0, 0, 0, 0, 0, DRAIN_F, 16);
        applyStimulus("drain_4",       0, 0, 0, 0, 0, 0, 0, 0, 0, DRAIN_F, 17);
        applyStimulus("halted",        1, 0, 1, 0, 0, 0, 0, 0, 0, HALT_F,  18);
        applyStimulus("halted_frozen", 1, 1, 0, 0, 0, 0, 0, 0, 0, HALT_F,  18);

        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d pending required=0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central controller for the five-stage MIPS pipeline. Drives the PC enable and the enable, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Sequences start, continuous run, single-step (debug) and halt-drain, and resolves load-use stalls and taken-branch flushes.
- Sits beside the datapath; its outputs feed the stage registers directly.

Parameters:
- RNBITS, 5, register-index width.
- DRAIN_CYCLES, 4, cycles needed to retire in-flight instructions after HALT is decoded.
- CNTBITS, 32, width of the retired-cycle counter.

Ports:
- i_clk  in  1  clock; FSM updates on posedge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  level; leave IDLE.
- i_mode_step  in  1  1 = single-step mode, 0 = continuous.
- i_step  in  1  step request; rising edge detected internally.
- i_halt_detected  in  1  HALT opcode present in ID.
- i_ID_rs  in  RNBITS  rs field of the instruction in ID.
- i_ID_rt  in  RNBITS  rt field of the instruction in ID.
- i_EX_RegistroDestino  in  RNBITS  destination register in EX.
- i_EX_MemRead  in  1  instruction in EX is a load.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- o_pc_en  out  1  PC update enable.
- o_IF_ID_en  out  1  IF/ID register enable.
- o_ID_EX_en  out  1  ID/EX register enable.
- o_EX_MEM_en  out  1  EX/MEM register enable.
- o_MEM_WB_en  out  1  MEM/WB register enable.
- o_IF_ID_flush  out  1  load NOP into IF/ID.
- o_ID_EX_bubble  out  1  zero ID/EX control fields.
- o_running  out  1  state is RUN or STEP_EXEC.
- o_halted  out  1  state is HALTED.
- o_step_done  out  1  one-cycle pulse after each step completes.
- o_cycle_count  out  CNTBITS  count of cycles with o_MEM_WB_en=1.

Behaviour:
- States: IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, HALTED. Registered on posedge.
- Enable, flush and bubble outputs are combinational from the current state plus hazard inputs, so the negedge-clocked stage registers sample them mid-cycle.
- Reset (async, any state): state=IDLE, drain counter=0, step-edge register=0, o_cycle_count=0. All enables, flush, bubble, o_running, o_halted and o_step_done are 0.
- IDLE: all enables 0. On i_start: if i_mode_step=1 go to STEP_WAIT, else go to RUN.
- Advancing states (RUN, STEP_EXEC): all enables default to 1.
- Load-use stall condition: i_EX_MemRead=1 AND i_EX_RegistroDestino != 0 AND (i_EX_RegistroDestino == i_ID_rs OR i_EX_RegistroDestino == i_ID_rt). When true:
  - o_pc_en=0 and o_IF_ID_en=0.
  - o_ID_EX_bubble=1.
  - o_ID_EX_en, o_EX_MEM_en and o_MEM_WB_en stay 1.
- o_IF_ID_flush = i_branch_taken AND NOT stall. A stall suppresses the flush; the branch re-resolves on the next cycle.
- HALT: i_halt_detected AND NOT stall → DRAIN, with drain counter loaded to DRAIN_CYCLES. HALT with stall is deferred.
- RUN with i_mode_step=1 → STEP_WAIT at the next edge.
- STEP_WAIT:
  - All enables 0.
  - i_mode_step=0 → RUN.
  - Rising edge of i_step → STEP_EXEC. Holding i_step high yields one step only.
- STEP_EXEC:
  - Exactly one cycle, with RUN rules applied.
  - Next state is STEP_WAIT, or DRAIN on HALT.
  - o_step_done=1 in the following cycle.
- DRAIN:
  - o_pc_en=0, o_IF_ID_en=0, o_ID_EX_bubble=1.
  - o_ID_EX_en, o_EX_MEM_en and o_MEM_WB_en are 1.
  - Counter decrements each cycle and is free-running, including in step mode; hazard inputs are ignored.
  - Counter==1 → HALTED.
- HALTED: all enables 0, o_halted=1. i_start and i_step are ignored; only reset exits.
- o_cycle_count increments on posedge when o_MEM_WB_en=1 and saturates at all-ones.

Optional Feature:
PIPE_SEQ_BREAKPOINT_EN
- Defined:
  - Adds ports i_bp_valid (1), i_bp_addr (32) and i_pc (32).
  - In RUN, if i_bp_valid=1 and i_pc==i_bp_addr, the cycle's enables are all 0 and the next state is STEP_WAIT.
  - Leaving STEP_WAIT via a step executes the matching instruction without re-triggering; a one-shot flag is cleared when i_pc changes.
- Undefined: no breakpoint ports and no breakpoint logic.

Test Plan:
- Reset mid-operation: RUN for 7 cycles, then drop i_reset_n between edges → all outputs 0 immediately and o_cycle_count=0. Release, then i_start=1 → RUN next edge.
- Load-use stall: RUN, i_EX_MemRead=1, EX dest=5, i_ID_rt=5 → o_pc_en=0, o_IF_ID_en=0, o_ID_EX_bubble=1, o_EX_MEM_en=1, o_MEM_WB_en=1. Repeat with EX dest=0 → no stall.
- Branch versus stall: i_branch_taken=1 alone → o_IF_ID_flush=1. Same cycle with load-use stall (dest=3, rs=3) → flush=0, stall asserted.
- Halt drain, DRAIN_CYCLES=4: i_halt_detected at cycle N → o_MEM_WB_en=1 in N+1..N+4 with bubble=1, o_halted=1 from N+5. o_cycle_count then frozen, and i_start is ignored.
- Step mode: i_start with i_mode_step=1, i_step held high 10 cycles → exactly one cycle of enables, one o_step_done pulse, o_cycle_count +1. Second i_step edge → +1 again. i_mode_step=0 → RUN.
- With PIPE_SEQ_BREAKPOINT_EN: i_bp_addr=0x20, i_pc reaches 0x20 → enables 0 that cycle, state STEP_WAIT. One step advances past 0x20 without re-trigger.
